vga_sprite_motion_ctrl: RTL and testbench
=========================================

Name: vga_sprite_motion_ctrl

Overview:
- Local-bus controller that owns and sequences the sprite0 control register of the VGA sprite engine.
- Holds a shadow copy of the 32-bit sprite register and applies per-frame velocity with edge bounce.
- Arbitrates host writes against motion updates into that shadow, then issues a single write strobe to the sprite engine's register port.
- Sits in the clk_lb domain between the local-bus decoder and vga_sprite. frame_tick is synchronized upstream.

Parameters:
- X_MAX_RST, 12'd640, reset value of the horizontal bound in pixels.
- Y_MAX_RST, 12'd480, reset value of the vertical bound in lines.

Ports:
- clk_lb  in  1  local-bus clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- lb_wr  in  1  local-bus write strobe.
- lb_rd  in  1  local-bus read strobe.
- lb_addr  in  32  byte address; [3:2] selects the register.
- lb_wr_d  in  32  write data.
- lb_cs_motion  in  1  chip select for this block.
- lb_rd_d  out  32  read data, valid 1 cycle after lb_rd.
- lb_rd_rdy  out  1  read-valid pulse.
- frame_tick  in  1  single-cycle start-of-frame pulse, already in clk_lb.
- spr_wr  out  1  1-cycle write strobe to the sprite register; top ties it to lb_cs_sprite_reg/lb_wr.
- spr_wr_d  out  32  sprite register value, held stable between strobes.
- busy  out  1  state != IDLE.
- overrun  out  1  sticky; set when frame_tick arrives while busy.

Behaviour:
- Reset values: lb_rd_d=0, lb_rd_rdy=0, spr_wr=0, spr_wr_d=0, busy=0, overrun=0. All registers take reset values; BOUNDS={Y_MAX_RST,X_MAX_RST}.
- Register map (addr[3:2]):
  - 0 CTRL: [0] run, [1] bounce_en, [2] overrun (write 1 clears).
  - 1 VEL: [7:0] signed dx, [15:8] signed dy.
  - 2 BOUNDS: [11:0] x_max, [23:12] y_max.
  - 3 SHADOW: full sprite word. Fields: x_pos[10:0], y_pos[20:11], x_size[24:21], y_size[29:25], zoom[31:30].
- Sprite footprint: w = 4*x_size+4 pixels, h = 4*y_size+4 lines.
- State machine:
  - IDLE: if frame_tick and run, go to CALC_X.
  - CALC_X: one cycle; go to CALC_Y.
  - CALC_Y: one cycle; go to WRITE.
  - WRITE: spr_wr=1 for one cycle, spr_wr_d=shadow; go to IDLE.
- Host SHADOW write in IDLE: loads shadow, then enters WRITE next cycle.
- Arithmetic:
  - 13-bit signed: nx = x_pos + sext(dx).
  - If nx < 0: x_pos=0. If nx + w > x_max: x_pos = x_max - w. Otherwise x_pos = nx[10:0].
  - On either clamp with bounce_en=1, dx is negated. Negating -128 gives +127. With bounce_en=0, clamp only and dx is unchanged.
  - Y axis is identical with dy, h, y_max and y_pos[9:0].
  - If w > x_max: x_pos=0 and dx is unchanged (same rule for Y).
- Arbitration:
  - Host write to SHADOW/VEL in CALC_X or CALC_Y wins. Host data is stored, the motion update in progress is discarded, and the FSM goes to WRITE carrying the host shadow.
  - Host write to SHADOW during WRITE is stored and causes a second WRITE on the next cycle (pending flag).
  - Host write in the same cycle as frame_tick in IDLE: host write takes effect and the tick is dropped. This does not set overrun.
- frame_tick while busy is ignored and sets overrun. A simultaneous CTRL[2] clear in the same cycle loses to the set.
- Clearing run mid-sequence completes the current sequence.
- Reset mid-sequence aborts immediately. No spr_wr is issued.
- Reads: lb_rd_d returns the register value 1 cycle after lb_rd with lb_cs_motion; lb_rd_rdy pulses in the same cycle. Unselected reads return 0 with no rdy.

Decomposition:
- Package vga_sprite_pkg:
  - Register offsets.
  - Field bit positions of the sprite word: X_LSB/MSB, Y_LSB/MSB, XS, YS, ZOOM.
  - FSM state encodings.
- Sub-module vga_sprite_axis_step: one-axis clamp/bounce combinational step, instantiated twice (X, Y).

Test Plan:
- Reset, read all four registers -> CTRL=0, VEL=0, BOUNDS=0x1E0280, SHADOW=0; spr_wr never asserted.
- Write SHADOW=0x0000_0064 -> exactly one spr_wr on the 2nd cycle after the write, spr_wr_d=0x64.
- run=1, bounce_en=1, x_pos=100, dx=+5, x_size=3, one frame_tick -> spr_wr_d x_pos=105, 3 cycles after tick.
- x_pos=620, w=16, x_max=640, dx=+8 -> x_pos=624, dx reads back 0xF8. Next tick -> x_pos=616.
- dx=-128 at x_pos=50 -> x_pos=0, dx=+127.
- frame_tick on the CALC_X cycle -> overrun=1, CTRL[2]=1; write 1 to CTRL[2] -> cleared. Host SHADOW write during CALC_Y -> spr_wr_d equals host value, not the motion result.

Source files
------------

// File: rtl/vga_sprite_pkg.sv
// ---------------------------------------------------------------------------
// vga_sprite_pkg
//   Shared definitions for the sprite motion controller:
//   - local-bus register offsets (lb_addr[3:2])
//   - bit positions of the fields inside the 32-bit sprite word
//   - motion sequencer state encoding
//   - velocity negation helper used by the bounce logic
// ---------------------------------------------------------------------------
package vga_sprite_pkg;

    // Register offsets, selected by lb_addr[3:2]
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_VEL    = 2'd1;
    localparam logic [1:0] REG_BOUNDS = 2'd2;
    localparam logic [1:0] REG_SHADOW = 2'd3;

    // Sprite word field positions
    localparam int X_LSB    = 0;
    localparam int X_MSB    = 10;
    localparam int Y_LSB    = 11;
    localparam int Y_MSB    = 20;
    localparam int XS_LSB   = 21;
    localparam int XS_MSB   = 24;
    localparam int YS_LSB   = 25;
    localparam int YS_MSB   = 29;
    localparam int ZOOM_LSB = 30;
    localparam int ZOOM_MSB = 31;

    // Motion sequencer states
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CALC_X = 2'd1,
        S_CALC_Y = 2'd2,
        S_WRITE  = 2'd3
    } state_t;

    // Two's complement negation that saturates: -(-128) gives +127.
    function automatic logic [7:0] vel_negate(input logic [7:0] v);
        if (v == 8'h80) begin
            return 8'h7F;
        end
        return ~v + 8'd1;
    endfunction

endpackage

// File: rtl/vga_sprite_axis_step.sv
// ---------------------------------------------------------------------------
// vga_sprite_axis_step
//   Combinational one-axis motion step with edge clamp and optional bounce.
//   Ports:
//     pos_i       current position (POS_W bits, unsigned)
//     size_i      size code; footprint = 4*size+4
//     vel_i       signed 8-bit velocity
//     max_i       12-bit bound
//     bounce_en_i negate velocity when a clamp happens
//     pos_o       next position
//     vel_o       next velocity
// ---------------------------------------------------------------------------
module vga_sprite_axis_step
    import vga_sprite_pkg::*;
#(
    parameter int POS_W  = 11,
    parameter int SIZE_W = 4
) (
    input  logic [POS_W-1:0]  pos_i,
    input  logic [SIZE_W-1:0] size_i,
    input  logic [7:0]        vel_i,
    input  logic [11:0]       max_i,
    input  logic              bounce_en_i,
    output logic [POS_W-1:0]  pos_o,
    output logic [7:0]        vel_o
);

    // 14-bit signed working width covers pos+vel+footprint without overflow.
    logic signed [13:0] pos_ext;
    logic signed [13:0] vel_ext;
    logic signed [13:0] extent;
    logic signed [13:0] bound;
    logic signed [13:0] next_pos;
    logic signed [13:0] far_edge;

    always_comb begin
        pos_ext  = 14'(pos_i);
        vel_ext  = {{6{vel_i[7]}}, vel_i};
        extent   = (14'(size_i) << 2) + 14'd4;
        bound    = 14'(max_i);
        next_pos = pos_ext + vel_ext;
        far_edge = next_pos + extent;

        pos_o = next_pos[POS_W-1:0];
        vel_o = vel_i;

        if (extent > bound) begin
            // Sprite larger than the playfield: pin to 0, keep velocity.
            pos_o = '0;
        end else if (next_pos < 14'sd0) begin
            pos_o = '0;
            if (bounce_en_i) begin
                vel_o = vel_negate(vel_i);
            end
        end else if (far_edge > bound) begin
            pos_o = POS_W'(bound - extent);
            if (bounce_en_i) begin
                vel_o = vel_negate(vel_i);
            end
        end
    end

endmodule

// File: rtl/vga_sprite_motion_ctrl.sv
// ---------------------------------------------------------------------------
// vga_sprite_motion_ctrl
//   Owns a shadow copy of the sprite0 register, applies per-frame velocity
//   with edge clamp/bounce, arbitrates host writes against motion updates,
//   and pushes the shadow to the sprite engine with a one-cycle strobe.
//   Ports:
//     clk_lb, reset_n           clock, async active-low reset
//     lb_wr/lb_rd/lb_addr/
//     lb_wr_d/lb_cs_motion      local-bus slave interface (addr[3:2] = reg)
//     lb_rd_d, lb_rd_rdy        read data and read-valid pulse (1 cycle later)
//     frame_tick                start-of-frame pulse (already in clk_lb)
//     spr_wr, spr_wr_d          strobe and value for the sprite register
//     busy                      sequencer not idle
//     overrun                   sticky: frame_tick seen while busy
//     dbg_state_o               current sequencer state
//
//   Handshake semantics: there is no back-pressure anywhere. A bus access
//   is accepted on every clock edge where lb_cs_motion and lb_wr/lb_rd are
//   high; a read answers with lb_rd_rdy high for exactly one cycle together
//   with lb_rd_d. spr_wr is a one-cycle strobe that the sprite engine must
//   take unconditionally; spr_wr_d holds its value between strobes.
// ---------------------------------------------------------------------------
module vga_sprite_motion_ctrl
    import vga_sprite_pkg::*;
#(
    parameter logic [11:0] X_MAX_RST = 12'd640,
    parameter logic [11:0] Y_MAX_RST = 12'd480
) (
    input  logic        clk_lb,
    input  logic        reset_n,
    input  logic        lb_wr,
    input  logic        lb_rd,
    input  logic [31:0] lb_addr,
    input  logic [31:0] lb_wr_d,
    input  logic        lb_cs_motion,
    output logic [31:0] lb_rd_d,
    output logic        lb_rd_rdy,
    input  logic        frame_tick,
    output logic        spr_wr,
    output logic [31:0] spr_wr_d,
    output logic        busy,
    output logic        overrun,
    output state_t      dbg_state_o
);

    state_t      state_q, state_d;
    logic        run_q, run_d;
    logic        bnc_q, bnc_d;
    logic        ovr_q, ovr_d;
    logic [7:0]  dx_q, dx_d;
    logic [7:0]  dy_q, dy_d;
    logic [11:0] xmax_q, xmax_d;
    logic [11:0] ymax_q, ymax_d;
    logic [31:0] shadow_q, shadow_d;
    logic [10:0] xres_q, xres_d;     // X result held from CALC_X until commit
    logic [7:0]  dxres_q, dxres_d;
    logic        strobe_q, strobe_d;
    logic [31:0] word_q, word_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rrdy_q, rrdy_d;

    // Bus decode. Only addr[3:2] selects a register.
    logic [1:0] reg_sel;
    logic       host_wr;
    logic       wr_ctrl, wr_vel, wr_bounds, wr_shadow;
    logic       host_abort;
    logic       unused_addr;

    assign reg_sel     = lb_addr[3:2];
    assign host_wr     = lb_wr & lb_cs_motion;
    assign wr_ctrl     = host_wr && (reg_sel == REG_CTRL);
    assign wr_vel      = host_wr && (reg_sel == REG_VEL);
    assign wr_bounds   = host_wr && (reg_sel == REG_BOUNDS);
    assign wr_shadow   = host_wr && (reg_sel == REG_SHADOW);
    assign unused_addr = ^{lb_addr[31:4], lb_addr[1:0]};

    // A host SHADOW/VEL write while computing discards the motion update.
    assign host_abort = ((state_q == S_CALC_X) || (state_q == S_CALC_Y)) &&
                        (wr_shadow || wr_vel);

    // Per-axis motion step, evaluated on the live shadow/velocity.
    logic [10:0] x_step_pos;
    logic [7:0]  x_step_vel;
    logic [9:0]  y_step_pos;
    logic [7:0]  y_step_vel;

    vga_sprite_axis_step #(
        .POS_W  (11),
        .SIZE_W (4)
    ) u_step_x (
        .pos_i       (shadow_q[X_MSB:X_LSB]),
        .size_i      (shadow_q[XS_MSB:XS_LSB]),
        .vel_i       (dx_q),
        .max_i       (xmax_q),
        .bounce_en_i (bnc_q),
        .pos_o       (x_step_pos),
        .vel_o       (x_step_vel)
    );

    vga_sprite_axis_step #(
        .POS_W  (10),
        .SIZE_W (5)
    ) u_step_y (
        .pos_i       (shadow_q[Y_MSB:Y_LSB]),
        .size_i      (shadow_q[YS_MSB:YS_LSB]),
        .vel_i       (dy_q),
        .max_i       (ymax_q),
        .bounce_en_i (bnc_q),
        .pos_o       (y_step_pos),
        .vel_o       (y_step_vel)
    );

    // ------------------------------------------------------------------
    // Sequencer: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_lb or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Sequencer: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                // Any host write in IDLE swallows a coincident frame_tick.
                if (wr_shadow) begin
                    state_d = S_WRITE;
                end else if (!host_wr && frame_tick && run_q) begin
                    state_d = S_CALC_X;
                end
            end
            S_CALC_X: state_d = host_abort ? S_WRITE : S_CALC_Y;
            S_CALC_Y: state_d = S_WRITE;
            // A SHADOW write landing during WRITE queues a second WRITE.
            S_WRITE:  state_d = wr_shadow ? S_WRITE : S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------
    always_comb begin
        run_d    = run_q;
        bnc_d    = bnc_q;
        ovr_d    = ovr_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        xmax_d   = xmax_q;
        ymax_d   = ymax_q;
        shadow_d = shadow_q;
        xres_d   = xres_q;
        dxres_d  = dxres_q;
        strobe_d = 1'b0;
        word_d   = word_q;

        // Host register writes always land, in any state.
        if (wr_ctrl) begin
            run_d = lb_wr_d[0];
            bnc_d = lb_wr_d[1];
            if (lb_wr_d[2]) begin
                ovr_d = 1'b0;
            end
        end
        if (wr_vel) begin
            dx_d = lb_wr_d[7:0];
            dy_d = lb_wr_d[15:8];
        end
        if (wr_bounds) begin
            xmax_d = lb_wr_d[11:0];
            ymax_d = lb_wr_d[23:12];
        end
        if (wr_shadow) begin
            shadow_d = lb_wr_d;
        end

        // Set dominates a same-cycle write-1-to-clear.
        if (frame_tick && (state_q != S_IDLE)) begin
            ovr_d = 1'b1;
        end

        case (state_q)
            S_CALC_X: begin
                if (!host_abort) begin
                    xres_d  = x_step_pos;
                    dxres_d = x_step_vel;
                end
            end
            S_CALC_Y: begin
                // Both axes commit together so an abort leaves no half update.
                if (!host_abort) begin
                    shadow_d[X_MSB:X_LSB] = xres_q;
                    shadow_d[Y_MSB:Y_LSB] = y_step_pos;
                    dx_d                  = dxres_q;
                    dy_d                  = y_step_vel;
                end
            end
            S_WRITE: begin
                strobe_d = 1'b1;
                word_d   = shadow_q;
            end
            default: begin
            end
        endcase
    end

    // Read port
    always_comb begin
        rdata_d = 32'd0;
        rrdy_d  = 1'b0;
        if (lb_rd && lb_cs_motion) begin
            rrdy_d = 1'b1;
            case (reg_sel)
                REG_CTRL:   rdata_d = {29'd0, ovr_q, bnc_q, run_q};
                REG_VEL:    rdata_d = {16'd0, dy_q, dx_q};
                REG_BOUNDS: rdata_d = {8'd0, ymax_q, xmax_q};
                REG_SHADOW: rdata_d = shadow_q;
                default:    rdata_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk_lb or negedge reset_n) begin
        if (!reset_n) begin
            run_q    <= 1'b0;
            bnc_q    <= 1'b0;
            ovr_q    <= 1'b0;
            dx_q     <= 8'd0;
            dy_q     <= 8'd0;
            xmax_q   <= X_MAX_RST;
            ymax_q   <= Y_MAX_RST;
            shadow_q <= 32'd0;
            xres_q   <= 11'd0;
            dxres_q  <= 8'd0;
            strobe_q <= 1'b0;
            word_q   <= 32'd0;
            rdata_q  <= 32'd0;
            rrdy_q   <= 1'b0;
        end else begin
            run_q    <= run_d;
            bnc_q    <= bnc_d;
            ovr_q    <= ovr_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            xmax_q   <= xmax_d;
            ymax_q   <= ymax_d;
            shadow_q <= shadow_d;
            xres_q   <= xres_d;
            dxres_q  <= dxres_d;
            strobe_q <= strobe_d;
            word_q   <= word_d;
            rdata_q  <= rdata_d;
            rrdy_q   <= rrdy_d;
        end
    end

    assign lb_rd_d     = rdata_q;
    assign lb_rd_rdy   = rrdy_q;
    assign spr_wr      = strobe_q;
    assign spr_wr_d    = word_q;
    assign busy        = (state_q != S_IDLE);
    assign overrun     = ovr_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_vga_sprite_motion_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vga_sprite_motion_ctrl
//   Directed plus randomized stimulus for vga_sprite_motion_ctrl. A simple
//   behavioural model (integers, one function per axis) predicts register
//   contents and the sequence of sprite words; a monitor pops the expected
//   word queue on every spr_wr strobe.
// ---------------------------------------------------------------------------
module tb_vga_sprite_motion_ctrl;
    import vga_sprite_pkg::*;

    // ---------------- clock / reset ----------------
    logic        clk_lb = 1'b0;
    logic        reset_n = 1'b0;
    logic        lb_wr = 1'b0;
    logic        lb_rd = 1'b0;
    logic [31:0] lb_addr = 32'd0;
    logic [31:0] lb_wr_d = 32'd0;
    logic        lb_cs_motion = 1'b0;
    logic        frame_tick = 1'b0;
    logic [31:0] lb_rd_d;
    logic        lb_rd_rdy;
    logic        spr_wr;
    logic [31:0] spr_wr_d;
    logic        busy;
    logic        overrun;
    state_t      dbg_state;

    always #5 clk_lb = ~clk_lb;

    vga_sprite_motion_ctrl dut (
        .clk_lb       (clk_lb),
        .reset_n      (reset_n),
        .lb_wr        (lb_wr),
        .lb_rd        (lb_rd),
        .lb_addr      (lb_addr),
        .lb_wr_d      (lb_wr_d),
        .lb_cs_motion (lb_cs_motion),
        .lb_rd_d      (lb_rd_d),
        .lb_rd_rdy    (lb_rd_rdy),
        .frame_tick   (frame_tick),
        .spr_wr       (spr_wr),
        .spr_wr_d     (spr_wr_d),
        .busy         (busy),
        .overrun      (overrun),
        .dbg_state_o  (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];

    // ---------------- reference model ----------------
    bit          m_run, m_bnc, m_ovr;
    int          m_dx, m_dy, m_xmax, m_ymax;
    logic [31:0] m_shadow;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One axis of motion from the rules: footprint, clamp at 0 / max, bounce.
    function automatic void axis_model(input int pos, input int size, input int vel,
                                       input int max, input bit bnc,
                                       output int npos, output int nvel);
        int w;
        int n;
        w    = 4 * size + 4;
        n    = pos + vel;
        nvel = vel;
        if (w > max) begin
            npos = 0;
        end else if (n < 0) begin
            npos = 0;
            if (bnc) nvel = (vel == -128) ? 127 : -vel;
        end else if (n + w > max) begin
            npos = max - w;
            if (bnc) nvel = (vel == -128) ? 127 : -vel;
        end else begin
            npos = n;
        end
    endfunction

    function automatic void model_frame();
        int nx, ny, ndx, ndy;
        axis_model(int'(m_shadow[10:0]), int'(m_shadow[24:21]), m_dx, m_xmax, m_bnc, nx, ndx);
        axis_model(int'(m_shadow[20:11]), int'(m_shadow[29:25]), m_dy, m_ymax, m_bnc, ny, ndy);
        m_shadow[10:0]  = 11'(nx);
        m_shadow[20:11] = 10'(ny);
        m_dx = ndx;
        m_dy = ndy;
        exp_q.push_back(m_shadow);
    endfunction

    function automatic logic [31:0] model_ctrl();
        return {29'd0, m_ovr, m_bnc, m_run};
    endfunction

    function automatic logic [31:0] model_vel();
        return {16'd0, 8'(m_dy), 8'(m_dx)};
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk_lb) begin
        if (spr_wr === 1'b1) begin
            total++;
            assert (exp_q.size() > 0) else begin
                bad++;
                $error("FAIL spr_wr_unexpected: observed strobe data=%h expected no strobe", spr_wr_d);
            end
            if (exp_q.size() > 0) check("spr_wr_d", spr_wr_d, exp_q.pop_front());
        end
    end

    // ---------------- driver tasks (called right after a negedge) ----------------
    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        lb_addr      = {28'd0, a, 2'b00};
        lb_wr_d      = d;
        lb_wr        = 1'b1;
        lb_cs_motion = 1'b1;
        @(negedge clk_lb);
        lb_wr        = 1'b0;
        lb_cs_motion = 1'b0;
        case (a)
            2'd0: begin
                m_run = d[0];
                m_bnc = d[1];
                if (d[2]) m_ovr = 1'b0;
            end
            2'd1: begin
                m_dx = int'($signed(d[7:0]));
                m_dy = int'($signed(d[15:8]));
            end
            2'd2: begin
                m_xmax = int'(d[11:0]);
                m_ymax = int'(d[23:12]);
            end
            default: begin
                m_shadow = d;
                exp_q.push_back(d);
            end
        endcase
    endtask

    task automatic rd_check(input logic [1:0] a, input logic [31:0] exp, input string tag);
        lb_addr      = {28'd0, a, 2'b00};
        lb_rd        = 1'b1;
        lb_cs_motion = 1'b1;
        @(negedge clk_lb);
        lb_rd        = 1'b0;
        lb_cs_motion = 1'b0;
        check({tag, "_rdy"}, 32'(lb_rd_rdy), 32'd1);
        check(tag, lb_rd_d, exp);
    endtask

    task automatic tick(input bit apply);
        frame_tick = 1'b1;
        @(negedge clk_lb);
        frame_tick = 1'b0;
        if (apply) model_frame();
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 20) begin
            @(negedge clk_lb);
            n++;
        end
        total++;
        assert (busy === 1'b0) else begin
            bad++;
            $error("FAIL wait_idle: observed busy=%b expected 0", busy);
        end
        @(negedge clk_lb);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: observed no completion expected finish");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] sh;
        logic [31:0] hv;

        m_run = 0; m_bnc = 0; m_ovr = 0;
        m_dx = 0; m_dy = 0; m_xmax = 640; m_ymax = 480;
        m_shadow = 32'd0;

        // Reset values
        repeat (3) @(negedge clk_lb);
        check("rst_rd_d",   lb_rd_d, 32'd0);
        check("rst_rd_rdy", 32'(lb_rd_rdy), 32'd0);
        check("rst_spr_wr", 32'(spr_wr), 32'd0);
        check("rst_spr_d",  spr_wr_d, 32'd0);
        check("rst_busy",   32'(busy), 32'd0);
        check("rst_ovr",    32'(overrun), 32'd0);
        check("rst_state",  32'(dbg_state), 32'(S_IDLE));
        reset_n = 1'b1;
        @(negedge clk_lb);

        rd_check(2'd0, 32'd0,        "rst_ctrl");
        rd_check(2'd1, 32'd0,        "rst_vel");
        rd_check(2'd2, 32'h001E0280, "rst_bounds");
        rd_check(2'd3, 32'd0,        "rst_shadow");

        // Unselected read: no rdy, zero data
        lb_addr = 32'h8; lb_rd = 1'b1;
        @(negedge clk_lb);
        lb_rd = 1'b0;
        check("unsel_rdy",  32'(lb_rd_rdy), 32'd0);
        check("unsel_data", lb_rd_d, 32'd0);

        // SHADOW write: strobe on the 2nd cycle after the write
        bus_wr(2'd3, 32'h0000_0064);
        check("shw_c1", 32'(spr_wr), 32'd0);
        @(negedge clk_lb);
        check("shw_c2", 32'(spr_wr), 32'd1);
        check("shw_d",  spr_wr_d, 32'h64);
        @(negedge clk_lb);
        check("shw_c3", 32'(spr_wr), 32'd0);

        // Basic motion: x=100, dx=+5, x_size=3 -> 105, strobe 3 cycles after tick
        bus_wr(2'd3, (32'd3 << 21) | 32'd100);
        wait_idle();
        bus_wr(2'd1, 32'h0000_0005);
        bus_wr(2'd0, 32'h3);
        tick(1);
        check("mv_busy", 32'(busy), 32'd1);
        @(negedge clk_lb);
        check("mv_c1", 32'(spr_wr), 32'd0);
        @(negedge clk_lb);
        check("mv_c2", 32'(spr_wr), 32'd0);
        @(negedge clk_lb);
        check("mv_c3", 32'(spr_wr), 32'd1);
        check("mv_x", spr_wr_d & 32'h7FF, 32'd105);
        wait_idle();

        // Right edge bounce: 620+8 clamps to 624, dx -> -8; then 616
        bus_wr(2'd3, (32'd3 << 21) | 32'd620);
        wait_idle();
        bus_wr(2'd1, 32'h0000_0008);
        tick(1);
        wait_idle();
        check("edge_x1", spr_wr_d & 32'h7FF, 32'd624);
        rd_check(2'd1, 32'h0000_00F8, "edge_vel");
        tick(1);
        wait_idle();
        check("edge_x2", spr_wr_d & 32'h7FF, 32'd616);

        // Left edge with dx=-128 -> x=0, dx=+127
        bus_wr(2'd3, (32'd3 << 21) | 32'd50);
        wait_idle();
        bus_wr(2'd1, 32'h0000_0080);
        tick(1);
        wait_idle();
        check("neg128_x", spr_wr_d & 32'h7FF, 32'd0);
        rd_check(2'd1, 32'h0000_007F, "neg128_vel");

        // Sprite wider than bound: pinned to 0, velocity kept
        bus_wr(2'd2, (32'd480 << 12) | 32'd10);
        bus_wr(2'd3, (32'd3 << 21) | 32'd5);
        wait_idle();
        bus_wr(2'd1, 32'h0000_0003);
        tick(1);
        wait_idle();
        check("wide_x", spr_wr_d & 32'h7FF, 32'd0);
        rd_check(2'd1, 32'h0000_0003, "wide_vel");
        bus_wr(2'd2, (32'd480 << 12) | 32'd640);

        // Clamp without bounce: 630+20 -> 624, dx stays +20
        bus_wr(2'd0, 32'h1);
        bus_wr(2'd3, (32'd3 << 21) | 32'd630);
        wait_idle();
        bus_wr(2'd1, 32'h0000_0014);
        tick(1);
        wait_idle();
        check("nobnc_x", spr_wr_d & 32'h7FF, 32'd624);
        rd_check(2'd1, 32'h0000_0014, "nobnc_vel");
        bus_wr(2'd0, 32'h3);

        // Overrun: second tick during CALC_X
        tick(1);
        tick(0);
        m_ovr = 1'b1;
        wait_idle();
        check("ovr_set", 32'(overrun), 32'd1);
        rd_check(2'd0, model_ctrl(), "ovr_ctrl");
        bus_wr(2'd0, 32'h7);
        check("ovr_clr", 32'(overrun), 32'd0);
        rd_check(2'd0, model_ctrl(), "ovr_ctrl_clr");

        // Host write coincident with tick in IDLE: tick dropped, no overrun
        frame_tick = 1'b1;
        bus_wr(2'd1, 32'h0000_0202);
        frame_tick = 1'b0;
        @(negedge clk_lb);
        check("coinc_busy", 32'(busy), 32'd0);
        check("coinc_ovr",  32'(overrun), 32'd0);
        rd_check(2'd1, model_vel(), "coinc_vel");

        // Host SHADOW write during CALC_Y wins over the motion result
        tick(0);
        @(negedge clk_lb);
        hv = $urandom;
        bus_wr(2'd3, hv);
        wait_idle();
        check("calcy_spr", spr_wr_d, hv);
        rd_check(2'd3, hv, "calcy_shadow");
        rd_check(2'd1, model_vel(), "calcy_vel");

        // Host SHADOW write during WRITE: motion word, then host word
        tick(1);
        @(negedge clk_lb);
        @(negedge clk_lb);
        hv = $urandom;
        bus_wr(2'd3, hv);
        wait_idle();
        check("dblw_spr", spr_wr_d, hv);

        // Randomized frames against the model
        for (int it = 0; it < 24; it++) begin
            bus_wr(2'd0, {30'd0, 1'($urandom_range(0, 1)), 1'b1});
            if ($urandom_range(0, 3) == 0) begin
                bus_wr(2'd2, (32'($urandom_range(50, 1023)) << 12) | 32'($urandom_range(50, 2047)));
            end
            sh = $urandom;
            sh[10:0]  = 11'($urandom_range(0, 700));
            sh[20:11] = 10'($urandom_range(0, 520));
            bus_wr(2'd3, sh);
            wait_idle();
            bus_wr(2'd1, 32'($urandom_range(0, 16'hFFFF)));
            for (int t = 0; t < int'($urandom_range(1, 3)); t++) begin
                tick(1);
                wait_idle();
            end
            rd_check(2'd3, m_shadow, "rnd_shadow");
            rd_check(2'd1, model_vel(), "rnd_vel");
        end

        repeat (4) @(negedge clk_lb);
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
